// File: rtl/exception_module.sv
// exception_module
//   Classifies two 8-bit minifloat operands (sign[7], exp[6:3], mant[2:0],
//   bias 7) against a requested operation. It raises registered exception
//   cause flags one cycle after the operands are sampled. There is no
//   handshake: every rising edge of clk samples a new operand set.
//
// Ports
//   clk    in   1  single clock, rising edge
//   rst    in   1  synchronous active-high reset; clears out and flags
//   op     in   2  00 add, 01 sub, 10 mul, 11 div
//   in0    in   8  first operand (in0 op in1)
//   in1    in   8  second operand
//   out    out  1  registered OR of all cause flags
//   flags  out  5  registered causes:
//                    [0] nan_in     [1] invalid   [2] div_zero
//                    [3] inf_in     [4] denorm_in
//
// Build option
//   EXCEPTION_DENORM_EN  when defined, denormal operands raise denorm_in.
//                        When undefined, flags[4] is held at 0 and
//                        denormals behave as ordinary finite nonzero values.
module exception_module (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  output logic       out,
  output logic [4:0] flags
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic       sgn0, sgn1;
  logic       exp_max0, exp_max1, exp_zero0, exp_zero1;
  logic       mant_nz0, mant_nz1;
  logic       nan0, nan1, inf0, inf1, zero0, zero1, den0, den1;
  logic       any_nan, any_inf;
  logic       nan_in, invalid, div_zero, inf_in, denorm_in;
  logic [4:0] flags_d;

  always_comb begin
    sgn0      = in0[7];
    sgn1      = in1[7];
    exp_max0  = (in0[6:3] == 4'hF);
    exp_max1  = (in1[6:3] == 4'hF);
    exp_zero0 = (in0[6:3] == 4'h0);
    exp_zero1 = (in1[6:3] == 4'h0);
    mant_nz0  = (in0[2:0] != 3'b000);
    mant_nz1  = (in1[2:0] != 3'b000);

    nan0  = exp_max0  &  mant_nz0;
    nan1  = exp_max1  &  mant_nz1;
    inf0  = exp_max0  & ~mant_nz0;
    inf1  = exp_max1  & ~mant_nz1;
    // Zero ignores the sign bit, so +0 and -0 classify identically.
    zero0 = exp_zero0 & ~mant_nz0;
    zero1 = exp_zero1 & ~mant_nz1;
    den0  = exp_zero0 &  mant_nz0;
    den1  = exp_zero1 &  mant_nz1;

    any_nan = nan0 | nan1;
    any_inf = inf0 | inf1;
  end

  always_comb begin
    nan_in    = any_nan;
    inf_in    = any_inf & ~any_nan;
    invalid   = 1'b0;
    div_zero  = 1'b0;
    denorm_in = 1'b0;

    if (!any_nan) begin
      unique case (op)
        OP_ADD: invalid = inf0 & inf1 & (sgn0 != sgn1);
        OP_SUB: invalid = inf0 & inf1 & (sgn0 == sgn1);
        OP_MUL: invalid = (zero0 & inf1) | (inf0 & zero1);
        OP_DIV: begin
          invalid  = (zero0 & zero1) | (inf0 & inf1);
          // A finite nonzero dividend is anything that is neither Inf nor Zero
          // once NaN is excluded. This includes denormals.
          div_zero = zero1 & ~inf0 & ~zero0;
        end
        default: invalid = 1'b0;
      endcase
    end

`ifdef EXCEPTION_DENORM_EN
    denorm_in = (den0 | den1) & ~any_nan;
`else
    denorm_in = 1'b0;
`endif

    flags_d = {denorm_in, inf_in, div_zero, invalid, nan_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 5'b00000;
      out   <= 1'b0;
    end else begin
      flags <= flags_d;
      out   <= |flags_d;
    end
  end

  // The denormal class feeds logic only when denorm detection is built in.
  logic unused_den;
  assign unused_den = den0 ^ den1;

endmodule

// File: tb/tb_exception_module.sv
module tb_exception_module;

  logic       clk;
  logic       rst;
  logic [1:0] op;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       out;
  logic [4:0] flags;

  int tests_run;
  int tests_failed;

`ifdef EXCEPTION_DENORM_EN
  localparam logic DN = 1'b1;
`else
  localparam logic DN = 1'b0;
`endif

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] f;
  } vec_t;

  exception_module dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .in0   (in0),
    .in1   (in1),
    .out   (out),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operand set, take one rising edge, then settle past the edge.
  task automatic drive(input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic r);
    op  = o;
    in0 = a;
    in1 = b;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(ADD, 8'h7F, 8'h78, 1'b1);
    tests_run++;
    if (out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out got %b want 0", out);
    end
    tests_run++;
    if (flags !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 00000", flags);
    end
  endtask

  task automatic test_basic();
    vec_t v [6];
    v = '{'{ADD, 8'h7F, 8'h00, 5'b00001},   // NaN in0
          '{ADD, 8'h38, 8'h38, 5'b00000},   // 1.0 + 1.0
          '{SUB, 8'h78, 8'h78, 5'b01010},   // +inf - +inf
          '{ADD, 8'h78, 8'h78, 5'b01000},   // +inf + +inf
          '{ADD, 8'h78, 8'hF8, 5'b01010},   // +inf + -inf
          '{SUB, 8'h78, 8'hF8, 5'b01000}};  // +inf - -inf
    for (int i = 0; i < 6; i++) begin
      drive(v[i].op, v[i].a, v[i].b, 1'b0);
      tests_run++;
      if (flags !== v[i].f) begin
        tests_failed++;
        $display("FAIL basic_flags[%0d] got %b want %b", i, flags, v[i].f);
      end
      tests_run++;
      if (out !== (|v[i].f)) begin
        tests_failed++;
        $display("FAIL basic_out[%0d] got %b want %b", i, out, |v[i].f);
      end
    end
  endtask

  task automatic test_div_mul();
    vec_t v [8];
    v = '{'{DIV, 8'h38, 8'h80, 5'b00100},         // 1 / -0
          '{DIV, 8'h00, 8'h00, 5'b00010},         // 0 / 0
          '{DIV, 8'h78, 8'h78, 5'b01010},         // inf / inf
          '{DIV, 8'h7F, 8'h00, 5'b00001},         // NaN / 0
          '{DIV, 8'h78, 8'h00, 5'b01000},         // inf / 0
          '{DIV, 8'h01, 8'h00, {DN, 4'b0100}},    // denorm / 0
          '{MUL, 8'h78, 8'h80, 5'b01010},         // inf * -0
          '{MUL, 8'h38, 8'hF8, 5'b01000}};        // 1 * -inf
    for (int i = 0; i < 8; i++) begin
      drive(v[i].op, v[i].a, v[i].b, 1'b0);
      tests_run++;
      if (flags !== v[i].f) begin
        tests_failed++;
        $display("FAIL divmul_flags[%0d] got %b want %b", i, flags, v[i].f);
      end
      tests_run++;
      if (out !== (|v[i].f)) begin
        tests_failed++;
        $display("FAIL divmul_out[%0d] got %b want %b", i, out, |v[i].f);
      end
    end
  endtask

  task automatic test_nan_priority();
    vec_t v [3];
    v = '{'{ADD, 8'hFF, 8'h78, 5'b00001},         // NaN with inf
          '{MUL, 8'h00, 8'h7F, 5'b00001},         // zero * NaN
          '{ADD, 8'h7F, 8'h01, 5'b00001}};        // NaN with denorm
    for (int i = 0; i < 3; i++) begin
      drive(v[i].op, v[i].a, v[i].b, 1'b0);
      tests_run++;
      if (flags !== v[i].f) begin
        tests_failed++;
        $display("FAIL nan_flags[%0d] got %b want %b", i, flags, v[i].f);
      end
    end
  endtask

  task automatic test_denorm();
    drive(MUL, 8'h01, 8'h38, 1'b0);
    tests_run++;
    if (flags !== {DN, 4'b0000}) begin
      tests_failed++;
      $display("FAIL denorm_flags got %b want %b", flags, {DN, 4'b0000});
    end
    tests_run++;
    if (out !== DN) begin
      tests_failed++;
      $display("FAIL denorm_out got %b want %b", out, DN);
    end
  endtask

  task automatic test_mid_reset();
    drive(MUL, 8'h00, 8'hF8, 1'b0);
    tests_run++;
    if (flags !== 5'b01010 || out !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_inv got out=%b flags=%b want out=1 flags=01010", out, flags);
    end
    drive(MUL, 8'h00, 8'hF8, 1'b1);
    tests_run++;
    if (flags !== 5'b00000 || out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got out=%b flags=%b want out=0 flags=00000", out, flags);
    end
    drive(SUB, 8'h78, 8'h78, 1'b0);
    tests_run++;
    if (flags !== 5'b01010 || out !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset got out=%b flags=%b want out=1 flags=01010", out, flags);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [4];
    v = '{'{ADD, 8'h7F, 8'h38, 5'b00001},
          '{ADD, 8'h38, 8'hB8, 5'b00000},
          '{DIV, 8'hB8, 8'h00, 5'b00100},
          '{ADD, 8'h38, 8'h38, 5'b00000}};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].op, v[i].a, v[i].b, 1'b0);
      tests_run++;
      if (flags !== v[i].f || out !== (|v[i].f)) begin
        tests_failed++;
        $display("FAIL b2b[%0d] got out=%b flags=%b want out=%b flags=%b",
                 i, out, flags, |v[i].f, v[i].f);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    op  = 2'b00;
    in0 = 8'h00;
    in1 = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_div_mul();
    test_nan_priority();
    test_denorm();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exception_module.md
EXCEPTION_MODULE -- requirements
Module: exception_module

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst as in the rest of the codebase.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port op SHALL be an input, 2 bits: operation code, encoded as follows.
- 00 = ADDITION
- 01 = SUBTRACTION
- 10 = MULTIPLICATION
- 11 = DIVISION
REQ-005 Port in0 SHALL be an input, 8 bits: first operand (in0 op in1).
REQ-006 Port in1 SHALL be an input, 8 bits: second operand.
REQ-007 Port out SHALL be an output, 1 bit: registered exception flag, the OR of all cause flags.
REQ-008 Port flags SHALL be an output, 5 bits, registered:
- [0] nan_in
- [1] invalid
- [2] div_zero
- [3] inf_in
- [4] denorm_in

Function
REQ-009 The operand format SHALL be 8-bit:
- sign [7], exponent [6:3], mantissa [2:0], bias 7.
- +inf = 0x78, -inf = 0xF8, canonical NaN = 0x7F, 1.0 = 0x38.
REQ-010 The operand classes SHALL be:
- NaN: exp=1111 and mant!=0.
- Inf: exp=1111 and mant=0.
- Zero: exp=0000 and mant=0, either sign.
- Denormal: exp=0000 and mant!=0.
REQ-011 nan_in SHALL be set when either operand is NaN, for every op.
REQ-012 invalid SHALL be set, for non-NaN operands only, in these cases:
- ADD: both operands Inf with opposite signs.
- SUB: both operands Inf with equal signs.
- MUL: one operand Zero and the other Inf.
- DIV: Zero/Zero, or Inf/Inf.
REQ-013 div_zero SHALL be set for DIV when in1 is Zero and in0 is finite and nonzero (a denormal in0 counts as nonzero); it SHALL NOT be set for 0/0 or NaN.
REQ-014 inf_in SHALL be set when either operand is Inf and neither is NaN.
REQ-015 out SHALL equal the OR of flags[4:0], computed from the same sampled inputs.
REQ-016 Latency SHALL be one cycle: inputs sampled at edge N appear on out/flags after edge N, and are held until the next edge.
REQ-017 The block SHALL have no handshake; every clock edge samples a new input set, and back-to-back changes each produce an independent result.
REQ-018 Flag checks SHALL be sign-agnostic for Zero (+0 and -0 are equivalent).

Reset
REQ-019 When rst=1 at a rising edge, out and flags SHALL be 0 after that edge, regardless of inputs.
REQ-020 Reset asserted mid-stream SHALL discard the current sample; the first valid result appears one edge after rst deasserts.

Configuration
REQ-021 Denormal detection SHALL be controlled by the macro EXCEPTION_DENORM_EN.
- Defined: denorm_in=1 when either operand is Denormal and no NaN is present, and this raises out.
- Undefined: flags[4] is tied to 0 and denormals are treated as ordinary finite nonzero values.

Verification
REQ-022 ADD, in0=0x7F, in1=0x00 -> after one edge: out=1, nan_in=1, invalid=0.
REQ-023 ADD, in0=0x38, in1=0x38 -> out=0, flags=00000.
REQ-024 SUB, in0=0x78, in1=0x78 -> out=1, invalid=1, inf_in=1; ADD 0x78+0x78 -> invalid=0, inf_in=1.
REQ-025 DIV, in0=0x38, in1=0x80 -> div_zero=1; DIV 0x00/0x00 -> invalid=1, div_zero=0.
REQ-026 MUL, in0=0x00, in1=0xF8 -> invalid=1, out=1; then rst=1 for one edge -> out=0, flags=0.
REQ-027 MUL, in0=0x01, in1=0x38 -> out=1 and denorm_in=1 with EXCEPTION_DENORM_EN defined; out=0 without it.
